// File: rtl/ccc_dyncfg_ctrl.sv
// Serial sequencer for the CCC dynamic-configuration port: shift, update, wait for PLL lock.
// Optional macro CCC_READBACK_EN adds RDATA, which captures the old config from SDOUT.
`timescale 1ns/1ps
module ccc_dyncfg_ctrl #(
    parameter int unsigned CFG_WIDTH    = 81,
    parameter int unsigned SCLK_DIV     = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                 FAB_CLK,
    input  logic                 M2F_RESET_N,
    input  logic                 CFG_REQ,
    input  logic [CFG_WIDTH-1:0] CFG_DATA,
    output logic                 CFG_BUSY,
    output logic                 CFG_DONE,
    output logic                 CFG_ERR,
    input  logic                 LOCK,
    output logic                 LOCKED,
    output logic                 MODE,
    output logic                 SDIN,
    output logic                 SCLK,
    output logic                 SSHIFT,
    output logic                 SUPDATE,
    input  logic                 SDOUT
`ifdef CCC_READBACK_EN
    ,
    output logic [CFG_WIDTH-1:0] RDATA
`endif
);

    localparam int unsigned BIT_W     = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam int unsigned DIV_W     = $clog2(2 * SCLK_DIV);
    localparam int unsigned TMO_W     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned LOCK_MASK = 4;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_WIDTH - 1);
    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] UPD_END  = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_UPDATE,
        S_WAIT_LOCK
    } state_e;

    state_e               state_q, state_d;
    logic [CFG_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 phase_q, phase_d;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           sync_q;
    logic                 half_end;
    logic                 lock_ok;

    assign half_end = (div_q == HALF_END);
    // A LOCKED still high from the old config is ignored until the mask window has passed.
    assign lock_ok  = sync_q[1] && (32'(tmo_q) >= LOCK_MASK);

    // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            tmo_q   <= '0;
            phase_q <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            tmo_q   <= tmo_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sync_q  <= {sync_q[0], LOCK};
        end
    end

    // NOTE: every variable gets a default first; a branch that skipped one would infer a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        tmo_d   = tmo_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CFG_REQ) begin
                    state_d = S_SHIFT;
                    shreg_d = CFG_DATA;
                    mode_d  = 1'b1;
                    bit_d   = '0;
                    div_d   = '0;
                    phase_d = 1'b0;
                end
            end
            S_SHIFT: begin
                div_d = div_q + 1'b1;
                if (half_end) begin
                    div_d   = '0;
                    phase_d = !phase_q;
                    // The falling SCLK edge moves the next bit onto SDIN.
                    if (phase_q) begin
                        shreg_d = shreg_q >> 1;
                        if (bit_q == LAST_BIT) begin
                            state_d = S_GAP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                div_d = div_q + 1'b1;
                if (half_end) begin
                    div_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                div_d = div_q + 1'b1;
                if (div_q == UPD_END) begin
                    div_d   = '0;
                    tmo_d   = '0;
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                tmo_d = tmo_q + 1'b1;
                if (lock_ok) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_END) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CFG_BUSY = (state_q != S_IDLE);
        SSHIFT   = (state_q == S_SHIFT);
        SCLK     = (state_q == S_SHIFT) && phase_q;
        SDIN     = (state_q == S_SHIFT) && shreg_q[0];
        SUPDATE  = (state_q == S_UPDATE);
    end

    assign MODE     = mode_q;
    assign CFG_DONE = done_q;
    assign CFG_ERR  = err_q;
    assign LOCKED   = sync_q[1];

`ifdef CCC_READBACK_EN
    logic [CFG_WIDTH-1:0] rb_q, rb_d;

    // The CCC presents its old LSB first, so filling from the top leaves it in original order.
    always_comb begin
        rb_d = rb_q;
        if (state_q == S_SHIFT && !phase_q && half_end) begin
            rb_d = {SDOUT, rb_q[CFG_WIDTH-1:1]};
        end
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            rb_q <= '0;
        end else begin
            rb_q <= rb_d;
        end
    end

    assign RDATA = rb_q;
`else
    logic unused_sdout;
    assign unused_sdout = SDOUT;
`endif

endmodule

// File: tb/tb_ccc_dyncfg_ctrl.sv
// Randomised scoreboard bench for ccc_dyncfg_ctrl: a CCC model drives LOCK/SDOUT, a monitor checks
// each DONE/ERR against a prediction pushed when the request was issued.
`timescale 1ns/1ps
module tb_ccc_dyncfg_ctrl;

    localparam int W   = 81;
    localparam int DIV = 2;
    localparam int TMO = 100;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] rb;
        bit           is_done;
        int           at;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic [W-1:0] data;
    logic         busy, done, err, locked, mode, sdin, sclk, sshift, supdate;
    logic         lock = 1'b0;
    logic         sdout = 1'b0;
`ifdef CCC_READBACK_EN
    logic [W-1:0] rdata;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_resp = 0;
    int   cur_delay = 1000;
    exp_t q[$];

    ccc_dyncfg_ctrl #(
        .CFG_WIDTH   (W),
        .SCLK_DIV    (DIV),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .FAB_CLK    (clk),
        .M2F_RESET_N(rst_n),
        .CFG_REQ    (req),
        .CFG_DATA   (data),
        .CFG_BUSY   (busy),
        .CFG_DONE   (done),
        .CFG_ERR    (err),
        .LOCK       (lock),
        .LOCKED     (locked),
        .MODE       (mode),
        .SDIN       (sdin),
        .SCLK       (sclk),
        .SSHIFT     (sshift),
        .SUPDATE    (supdate),
        .SDOUT      (sdout)
`ifdef CCC_READBACK_EN
        ,
        .RDATA      (rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {busy, done, err, locked, mode, sdin, sclk, sshift, supdate};
    endfunction

    // Lock is seen two cycles after LOCK rises (d<0: LOCK high throughout), but not before
    // WAIT_LOCK cycle 4; the response appears one cycle after the accepting cycle.
    function automatic void predict(input int d, output bit is_done, output int at);
        int seen;
        int first;
        seen  = (d < 0) ? 0 : d + 2;
        first = (seen > 4) ? seen : 4;
        if (first <= TMO - 1) begin
            is_done = 1'b1;
            at      = first + 1;
        end else begin
            is_done = 1'b0;
            at      = TMO;
        end
    endfunction

    // CCC model: serial chain clocked by SCLK, LOCK dropped on SUPDATE and raised cur_delay cycles
    // into the lock wait.
    logic [W-1:0] chain = 81'h1234;
    logic         m_prev_sclk = 1'b0;
    logic         m_prev_upd = 1'b0;
    int           m_wl = -1;

    always @(negedge clk) begin
        if (sclk && !m_prev_sclk) chain = {sdin, chain[W-1:1]};
        sdout = chain[0];
        if (supdate && !m_prev_upd) lock = (cur_delay < 0);
        if (!supdate && m_prev_upd) m_wl = 0;
        else if (m_wl >= 0) m_wl++;
        if (!busy) m_wl = -1;
        if (m_wl >= 0 && m_wl == cur_delay) lock = 1'b1;
        m_prev_sclk = sclk;
        m_prev_upd  = supdate;
    end

    // Monitor
    logic [W-1:0] stream;
    int           nbits, n_shift, n_upd, bad_hi, bad_sdin, hi_run, wl, mcyc, busy_rise;
    logic         prev_sclk, prev_sdin, prev_upd, prev_busy, resp_prev;
    exp_t         e_mon;

    initial mcyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stream = '0; nbits = 0; n_shift = 0; n_upd = 0; bad_hi = 0; bad_sdin = 0; hi_run = 0;
            wl = -1; busy_rise = 0;
            prev_sclk = 1'b0; prev_sdin = 1'b0; prev_upd = 1'b0; prev_busy = 1'b0; resp_prev = 1'b0;
        end else begin
            mcyc++;
            if (resp_prev) check("resp_pulse_width", 128'(done | err), 128'(0));
            resp_prev = 1'b0;
            if (busy && !prev_busy) busy_rise = mcyc;
            if (sclk && !prev_sclk) begin
                if (nbits == 0) check("first_sclk_rise", 128'(mcyc - busy_rise), 128'(DIV));
                if (nbits < W) stream[nbits] = sdin;
                nbits++;
            end
            if (sclk) hi_run++;
            else if (prev_sclk) begin
                if (hi_run != DIV) bad_hi++;
                hi_run = 0;
            end
            if (sclk && sdin != prev_sdin) bad_sdin++;
            if (sshift) n_shift++;
            if (supdate) n_upd++;
            if (!supdate && prev_upd) wl = 0;
            else if (wl >= 0) wl++;
            if (done || err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=done%0b/err%0b required=none", done, err);
                end else begin
                    e_mon = q.pop_front();
                    check("resp_done", 128'(done), 128'(e_mon.is_done));
                    check("resp_err", 128'(err), 128'(!e_mon.is_done));
                    check("resp_cycle", 128'(wl), 128'(e_mon.at));
                    check("sdin_stream", 128'(stream), 128'(e_mon.data));
                    check("sclk_rises", 128'(nbits), 128'(W));
                    check("sshift_cycles", 128'(n_shift), 128'(W * 2 * DIV));
                    check("supdate_cycles", 128'(n_upd), 128'(2 * DIV));
                    check("sclk_high_bad", 128'(bad_hi), 128'(0));
                    check("sdin_in_high_bad", 128'(bad_sdin), 128'(0));
                    check("busy_at_resp", 128'(busy), 128'(0));
                    check("mode_at_resp", 128'(mode), 128'(1));
`ifdef CCC_READBACK_EN
                    check("rdata", 128'(rdata), 128'(e_mon.rb));
`endif
                end
                n_resp++;
                resp_prev = 1'b1;
                stream = '0; nbits = 0; n_shift = 0; n_upd = 0; bad_hi = 0; bad_sdin = 0; hi_run = 0;
                wl = -1;
            end
            prev_sclk = sclk;
            prev_sdin = sdin;
            prev_upd  = supdate;
            prev_busy = busy;
        end
    end

    function automatic logic [W-1:0] rand_cfg();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic run_txn(input logic [W-1:0] cfg, input int d, input bit stray);
        exp_t e;
        int   start;
        bit   got;
        e.data = cfg;
        e.rb   = chain;
        predict(d, e.is_done, e.at);
        q.push_back(e);
        cur_delay = d;
        start = n_resp;
        @(negedge clk);
        req  = 1'b1;
        data = cfg;
        @(negedge clk);
        req  = 1'b0;
        data = rand_cfg();
        if (stray) begin
            repeat ($urandom_range(5, 250)) @(negedge clk);
            if (sshift) begin
                req  = 1'b1;
                data = rand_cfg();
                @(negedge clk);
                req  = 1'b0;
            end
        end
        got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(posedge clk);
            if (n_resp != start) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=no_resp required=resp_within_1500");
            q.delete();
            @(negedge clk) rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic abort_txn();
        int   start;
        int   rises;
        logic prev;
        cur_delay = 1000;
        start = n_resp;
        @(negedge clk);
        req  = 1'b1;
        data = rand_cfg();
        @(negedge clk);
        req   = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 2000 && !(rises == 40 && !sclk); i++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        if (rises != 40) begin
            checks++;
            errors++;
            $display("FAIL abort_reach_bit40 actual=%0d required=40", rises);
        end
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", 128'(outs()), 128'(0));
`ifdef CCC_READBACK_EN
        check("abort_rdata", 128'(rdata), 128'(0));
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_no_resp", 128'(n_resp), 128'(start));
        check("abort_mode", 128'(mode), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        int act;
        int d;
        rst_n = 1'b0;
        req   = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", 128'(outs()), 128'(0));
`ifdef CCC_READBACK_EN
        check("reset_rdata", 128'(rdata), 128'(0));
`endif
        @(negedge clk) rst_n = 1'b1;

        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (sclk || sshift || supdate || busy) act++;
        end
        check("idle_activity", 128'(act), 128'(0));
        check("idle_mode", 128'(mode), 128'(0));

        run_txn(81'h1_5555_0000_FFFF_A5A5_C3C3, 50, 1'b0);
        run_txn(rand_cfg(), 1000, 1'b1);
        run_txn(rand_cfg(), 97, 1'b0);
        run_txn(rand_cfg(), 98, 1'b0);
        run_txn(rand_cfg(), -1, 1'b1);
        abort_txn();
        run_txn(rand_cfg(), 10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 110));
            run_txn(rand_cfg(), d, 1'($urandom_range(0, 1)));
        end

        repeat (20) @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
